// File: rtl/display_mux.sv
// ---------------------------------------------------------------------------
// display_mux
//   Time-multiplexed driver for a row of common-anode 7-segment digits.
//   A shadow register holds the value on display, so digits_in may change
//   freely between loads. A scan counter selects one digit at a time. The
//   driver also supports leading-zero suppression, per-digit blinking and an
//   optional hex (A-F) decode.
//
//   Ports
//     clk         : single clock, rising edge
//     reset       : synchronous, active-high
//     digits_in   : 4*N_DIGITS code nibbles, [3:0] = digit 0 (LSD)
//     load        : captures digits_in into the shadow register
//     enable      : 0 blanks the display and parks the scanner at digit 0
//     blank_lz    : suppress leading zeros (digit 0 is never suppressed)
//     blink_mask  : per-digit blink enable
//     seg_out     : {a,b,c,d,e,f,g} in [6:0], active-low, registered
//     an_out      : digit select, active-low one-cold, registered
//     frame_done  : one-cycle pulse when the scan wraps back to digit 0
// ---------------------------------------------------------------------------
module display_mux #(
  parameter int N_DIGITS  = 3,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64,
  parameter int HEX_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  logic [4*N_DIGITS-1:0] r_shadow;
  logic [CW-1:0]         r_scan_cnt;
  logic [IW-1:0]         r_idx;
  logic [FW-1:0]         r_frame_cnt;
  logic                  r_blink_phase;
  logic                  r_active;     // enable was high on the previous edge
  logic [6:0]            r_seg;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame_done;

  logic                  w_first;
  logic                  w_scan_wrap;
  logic                  w_frame_wrap;
  logic                  w_phase_next;
  logic [IW-1:0]         w_idx_next;
  logic [4*N_DIGITS-1:0] w_value;
  logic [3:0]            w_code;
  logic                  w_upper_nonzero;
  logic                  w_lz_blank;
  logic                  w_blink_blank;
  logic [6:0]            w_seg_next;
  logic [N_DIGITS-1:0]   w_an_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (code)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001101;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = (HEX_EN != 0) ? 7'b0001000 : SEG_OFF;
      4'hB: seg = (HEX_EN != 0) ? 7'b1100000 : SEG_OFF;
      4'hC: seg = (HEX_EN != 0) ? 7'b0110001 : SEG_OFF;
      4'hD: seg = (HEX_EN != 0) ? 7'b1000010 : SEG_OFF;
      4'hE: seg = (HEX_EN != 0) ? 7'b0110000 : SEG_OFF;
      4'hF: seg = (HEX_EN != 0) ? 7'b0111000 : SEG_OFF;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Next-digit selection and segment pattern. The pattern is always computed
  // for the digit that becomes visible on this edge, so the registered
  // outputs line up with the new index.
  always_comb begin
    w_first         = 1'b0;
    w_scan_wrap     = 1'b0;
    w_frame_wrap    = 1'b0;
    w_phase_next    = r_blink_phase;
    w_idx_next      = '0;
    w_value         = r_shadow;
    w_code          = '0;
    w_upper_nonzero = 1'b0;
    w_lz_blank      = 1'b0;
    w_blink_blank   = 1'b0;
    w_seg_next      = SEG_OFF;
    w_an_next       = '1;

    w_first     = enable && !r_active;
    w_scan_wrap = enable && r_active && (r_scan_cnt == SCAN_LAST);

    if (w_first) begin
      w_idx_next = '0;
    end else if (r_idx == IDX_LAST) begin
      w_idx_next = '0;
    end else begin
      w_idx_next = r_idx + 1'b1;
    end

    w_frame_wrap = w_scan_wrap && (r_idx == IDX_LAST);
    // The phase that starts a new frame applies to that frame's first digit.
    if (w_frame_wrap && (r_frame_cnt == BLINK_LAST)) begin
      w_phase_next = ~r_blink_phase;
    end

    // A load on the same edge wins: display the value being captured.
    w_value = load ? digits_in : r_shadow;
    w_code  = w_value[int'(w_idx_next)*4 +: 4];

    for (int i = 0; i < N_DIGITS; i++) begin
      if ((i >= int'(w_idx_next)) && (w_value[i*4 +: 4] != 4'h0)) begin
        w_upper_nonzero = 1'b1;
      end
    end
    w_lz_blank    = blank_lz && (w_idx_next != '0) && !w_upper_nonzero;
    w_blink_blank = blink_mask[w_idx_next] && w_phase_next;

    if (w_lz_blank || w_blink_blank) begin
      w_seg_next = SEG_OFF;
    end else begin
      w_seg_next = decode(w_code);
    end
    // Anode stays selected even when the segments are blanked.
    w_an_next = ~(N_DIGITS'(1) << w_idx_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow      <= '0;
      r_scan_cnt    <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_active      <= 1'b0;
      r_seg         <= SEG_OFF;
      r_an          <= '1;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (load) begin
        r_shadow <= digits_in;
      end

      if (!enable) begin
        // Park the scanner; blink_phase is deliberately left alone.
        r_scan_cnt  <= '0;
        r_idx       <= '0;
        r_frame_cnt <= '0;
        r_active    <= 1'b0;
        r_seg       <= SEG_OFF;
        r_an        <= '1;
      end else begin
        r_active <= 1'b1;
        if (w_first) begin
          r_scan_cnt <= '0;
          r_idx      <= '0;
          r_seg      <= w_seg_next;
          r_an       <= w_an_next;
        end else if (w_scan_wrap) begin
          r_scan_cnt    <= '0;
          r_idx         <= w_idx_next;
          r_seg         <= w_seg_next;
          r_an          <= w_an_next;
          r_frame_done  <= w_frame_wrap;
          r_blink_phase <= w_phase_next;
          if (w_frame_wrap) begin
            r_frame_cnt <= (r_frame_cnt == BLINK_LAST) ? '0 : r_frame_cnt + 1'b1;
          end
        end else begin
          r_scan_cnt <= r_scan_cnt + 1'b1;
        end
      end
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_mux.sv
module tb_display_mux;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S1    = 7'b1001111;
  localparam logic [6:0] S5    = 7'b0100100;
  localparam logic [6:0] S7    = 7'b0001101;
  localparam logic [6:0] S9    = 7'b0000100;
  localparam logic [6:0] SA    = 7'b0001000;

  logic        clk;
  logic        reset;
  logic [11:0] digits_in;
  logic        load;
  logic        enable;
  logic        blank_lz;
  logic [2:0]  blink_mask;
  logic [6:0]  seg0, seg1;
  logic [2:0]  an0, an1;
  logic        fd0, fd1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] exp_seg[3];
  logic [2:0] exp_an[3];

  display_mux #(.N_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(2), .HEX_EN(0)) dut0 (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .enable(enable), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg_out(seg0), .an_out(an0), .frame_done(fd0)
  );

  display_mux #(.N_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(2), .HEX_EN(1)) dut1 (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .enable(enable), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg_out(seg1), .an_out(an1), .frame_done(fd1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] e_seg0,
                     input logic [6:0] e_seg1, input logic [2:0] e_an,
                     input logic e_fd);
    n_tests++;
    assert (seg0 === e_seg0) else begin
      n_fail++; $error("FAIL %s seg(hex0) got %b exp %b", tag, seg0, e_seg0);
    end
    n_tests++;
    assert (seg1 === e_seg1) else begin
      n_fail++; $error("FAIL %s seg(hex1) got %b exp %b", tag, seg1, e_seg1);
    end
    n_tests++;
    assert (an0 === e_an && an1 === e_an) else begin
      n_fail++; $error("FAIL %s an got %b/%b exp %b", tag, an0, an1, e_an);
    end
    n_tests++;
    assert (fd0 === e_fd && fd1 === e_fd) else begin
      n_fail++; $error("FAIL %s frame_done got %b/%b exp %b", tag, fd0, fd1, e_fd);
    end
  endtask

  initial begin
    int d;
    logic [6:0] s;
    exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011;

    reset = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0;
    blank_lz = 1'b0; blink_mask = '0;
    step(); step();
    chk("reset", S_OFF, S_OFF, 3'b111, 1'b0);

    // reset overrides load and enable
    load = 1'b1; digits_in = 12'h159; enable = 1'b1;
    step();
    chk("reset_over", S_OFF, S_OFF, 3'b111, 1'b0);
    reset = 1'b0; load = 1'b0; enable = 1'b0;
    step();
    chk("idle_off", S_OFF, S_OFF, 3'b111, 1'b0);

    // scan 0x159, load on the first enabled edge
    exp_seg[0] = S9; exp_seg[1] = S5; exp_seg[2] = S1;
    load = 1'b1; enable = 1'b1; digits_in = 12'h159;
    step();
    load = 1'b0;
    for (int k = 0; k < 24; k++) begin
      d = (k / 4) % 3;
      chk($sformatf("scan_k%0d", k), exp_seg[d], exp_seg[d], exp_an[d],
          (k % 12 == 0) && (k > 0));
      step();
    end

    // leading zeros, 0x007
    enable = 1'b0;
    step();
    chk("dis_off", S_OFF, S_OFF, 3'b111, 1'b0);
    blank_lz = 1'b1; load = 1'b1; digits_in = 12'h007;
    step();
    load = 1'b0;
    step();
    chk("dis_load", S_OFF, S_OFF, 3'b111, 1'b0);
    enable = 1'b1;
    step();
    exp_seg[0] = S7; exp_seg[1] = S_OFF; exp_seg[2] = S_OFF;
    for (int k = 0; k < 12; k++) begin
      d = k / 4;
      chk($sformatf("lz7_k%0d", k), exp_seg[d], exp_seg[d], exp_an[d], 1'b0);
      step();
    end

    // leading zeros, 0x000
    enable = 1'b0;
    step();
    load = 1'b1; digits_in = 12'h000;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    exp_seg[0] = S0;
    for (int k = 0; k < 12; k++) begin
      d = k / 4;
      chk($sformatf("lz0_k%0d", k), exp_seg[d], exp_seg[d], exp_an[d], 1'b0);
      step();
    end

    // blink on digit 0 starting from a clean reset
    reset = 1'b1;
    step();
    reset = 1'b0; blank_lz = 1'b0; blink_mask = 3'b001;
    load = 1'b1; digits_in = 12'h159; enable = 1'b1;
    step();
    load = 1'b0;
    exp_seg[0] = S9; exp_seg[1] = S5; exp_seg[2] = S1;
    for (int k = 0; k < 60; k++) begin
      d = (k / 4) % 3;
      s = exp_seg[d];
      if (d == 0 && k >= 24 && k < 48) s = S_OFF;
      chk($sformatf("blink_k%0d", k), s, s, exp_an[d],
          (k % 12 == 0) && (k > 0));
      step();
    end

    // hex decode of 0x00A
    reset = 1'b1;
    step();
    reset = 1'b0; blink_mask = '0;
    load = 1'b1; digits_in = 12'h00A; enable = 1'b1;
    step();
    load = 1'b0;
    chk("hex_d0", S_OFF, SA, 3'b110, 1'b0);
    step(); step(); step(); step();
    chk("hex_d1", S0, S0, 3'b101, 1'b0);

    // drop enable during digit 1, then re-enable
    enable = 1'b0;
    step();
    chk("en_drop", S_OFF, S_OFF, 3'b111, 1'b0);
    enable = 1'b1;
    step();
    exp_seg[0] = S_OFF; exp_seg[1] = S0; exp_seg[2] = S0;
    for (int k = 0; k < 12; k++) begin
      d = k / 4;
      s = (d == 0) ? SA : exp_seg[d];
      chk($sformatf("reen_k%0d", k), exp_seg[d], s, exp_an[d], 1'b0);
      if (k < 11) step();
    end

    // reset on the edge that would have wrapped the frame
    reset = 1'b1;
    step();
    chk("rst_mid", S_OFF, S_OFF, 3'b111, 1'b0);
    step();
    chk("rst_hold", S_OFF, S_OFF, 3'b111, 1'b0);
    reset = 1'b0;
    step();
    chk("rst_rel", S0, S0, 3'b110, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
